sprite_color_mapper_pipe: RTL and testbench
===========================================

// Module: sprite_color_mapper_pipe
// PURPOSE
//  Pipelined, parametrised pixel colour mapper between the VGA controller and the DAC pins.
//  Draws one 8x16 font-glyph hero sprite, NUM_BULLETS circular bullets and a blue gradient background.
//  Sprite state goes into frame-stable shadow registers at frame_start, so no tearing mid-frame.
//  The font ROM is synchronous, so the block is a fixed 2-stage pipeline.
// PARAMETERS
//  NUM_BULLETS   4    number of bullet channels (1..8)
//  BULLET_R      4    bullet radius in pixels (1..15)
//  COORD_W       10   DrawX/DrawY/sprite coordinate width
// PORTS
//  Clk           in   1                 system clock (pixel-clock enable handled upstream)
//  Reset_n       in   1                 asynchronous, active-low reset
//  frame_start   in   1                 1-cycle pulse at vsync: load shadow registers
//  pix_valid     in   1                 DrawX/DrawY are an active-area pixel
//  DrawX, DrawY  in   COORD_W each      current pixel coordinate
//  HeroX, HeroY  in   COORD_W each      hero top-left corner
//  glyph_code    in   7                 hero glyph index into the font ROM
//  transparent   in   1                 1: hero glyph background pixels show what lies under them
//  BulletX, BulletY  in  NUM_BULLETS*COORD_W each   bullet centres; channel i is in slice [i*COORD_W +: COORD_W]
//  bullet_en     in   NUM_BULLETS       per-channel draw enable
//  Red, Green, Blue  out  8 each        registered colour
//  rgb_valid     out  1                 Red/Green/Blue correspond to a pix_valid pixel
// BEHAVIOUR
//  Reset: all shadows, pipeline registers and outputs go to 0 asynchronously (bullet_en shadow = 0).
//   Reset asserted mid-frame flushes the pipeline. Nothing draws until the first frame_start after release.
//  Shadow load: on frame_start the shadows capture HeroX/Y, glyph_code, transparent, BulletX/Y and bullet_en.
//   A pixel presented in the same cycle as frame_start uses the OLD shadow values.
//  Latency: the pixel presented at cycle t produces Red/Green/Blue/rgb_valid at t+2, with no stalls.
//  Stage 0, combinational:
//   dx = DrawX - HeroX and dy = DrawY - HeroY, both signed (COORD_W+1) bits.
//   hero_on = 0<=dx<=7 && 0<=dy<=15.
//   ROM addr = {glyph_code, dy[3:0]} (11 bits) goes to the sync ROM.
//   Per bullet i: bx, by are signed (COORD_W+1) bits.
//   hit[i] = bullet_en[i] && (bx*bx + by*by <= BULLET_R*BULLET_R), compared at 2*(COORD_W+1) bits.
//  Stage 1 registers: hero_on, dx[2:0], hit vector, DrawX[9:3], pix_valid. ROM data is valid in this cycle.
//  Stage 2 registers: final colour, chosen by strict priority (highest first):
//   1) hero_on and glyph bit set (bit index 7-dx, MSB = leftmost) -> HERO_FG
//   2) hero_on and glyph bit clear and !transparent -> HERO_BG
//   3) any hit -> BULLET_RGB[lowest set index]
//   4) background: R=0, G=0, B = 8'h7F - {1'b0, DrawX[9:3]} (never underflows)
//  Blanking: if the stage-1 pix_valid is 0, the output is R=G=B=0 and rgb_valid=0.
//  Edges: sprites near 0 or the max coordinate give negative dx/by and must not wrap into a false hit.
//   Bullets that overlap resolve to the lowest index. Disabled channels never draw.
// STRUCTURE
//  Package sprite_pkg:
//   typedef rgb_t {logic [7:0] r, g, b;}
//   HERO_FG = 'hFF5500; HERO_BG = 'h005500
//   BULLET_RGB[8] colour table (index 0 = 'hFF5500)
//   GLYPH_W = 8, GLYPH_H = 16
//  Sub-module: font_rom_sync (11-bit addr, 8-bit data, registered output, 1-cycle latency).
//  Everything else (distance math, hit generation, priority mux, shadows) stays in this module.
// TESTING
//  1) Reset, then frame_start with HeroX=100, HeroY=50, glyph 'A', transparent=0; sweep row 50.
//     -> columns 100..107 give FG/BG exactly per the ROM row; column 108 gives background; latency is exactly 2.
//  2) Bullet 0 at (200,200), R=4, enabled. Pixels (204,200) and (203,202) are BULLET_RGB[0]; (204,201) and (205,200) are background.
//  3) Bullets 1 and 2 both at (300,300), both enabled -> BULLET_RGB[1]. Disable 1 at the next frame_start -> BULLET_RGB[2].
//  4) transparent=1, hero overlapping bullet 0. Glyph-clear pixel -> bullet colour. Glyph-set pixel -> HERO_FG.
//  5) Change HeroX mid-frame without frame_start -> no change in the output.
//     frame_start in the same cycle as a pixel -> that pixel uses the old position; the next pixel uses the new one.
//  6) pix_valid=0 -> RGB=0 and rgb_valid=0 two cycles later.
//     Assert Reset_n low mid-line -> outputs 0 immediately; after release no sprite draws until frame_start.

Source files
------------

// File: rtl/sprite_color_mapper_pipe_pkg.sv
// Shared types, colour constants and glyph geometry for the sprite colour mapper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam rgb_t HERO_FG = 24'hFF5500;
  localparam rgb_t HERO_BG = 24'h005500;

  // Index 0 deliberately matches the hero foreground; the rest are chosen
  // so that none has R=G=0 and could be mistaken for the blue background.
  localparam rgb_t BULLET_RGB [8] = '{
    24'hFF5500, 24'h00FF00, 24'hFF00FF, 24'hFFFF00,
    24'h00FFFF, 24'hFFFFFF, 24'hFF0000, 24'h808080
  };

  // Horizontal gradient: column group 0 is brightest; 0x7F - 0x7F is the
  // darkest case, so the subtraction can never underflow.
  function automatic rgb_t background_rgb(input logic [6:0] col);
    rgb_t c;
    c.r = 8'h00;
    c.g = 8'h00;
    c.b = 8'h7F - {1'b0, col};
    return c;
  endfunction

endpackage

// File: rtl/sprite_color_mapper_pipe_font_rom.sv
// Synchronous 8x16 glyph ROM: 11-bit address {glyph, row}, 8-bit row, MSB = leftmost pixel.
// Latency: 1 cycle (registered data output), new address accepted every cycle.
// Backpressure: none; the ROM is read every cycle.
// Ports: clk, rst_n (async, active-low), addr[10:0], data[7:0].
module font_rom_sync (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  // Reduced glyph set: 'A' (0x41) and a solid block (0x7F); every other
  // code is a blank cell.
  localparam logic [7:0] GLYPH_A [16] = '{
    8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
  };

  logic [7:0] row_d;

  always_comb begin
    row_d = 8'h00;
    case (addr[10:4])
      7'h41:   row_d = GLYPH_A[addr[3:0]];
      7'h7F:   row_d = 8'hFF;
      default: row_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= 8'h00;
    else        data <= row_d;
  end

endmodule

// File: rtl/sprite_color_mapper_pipe.sv
// Pixel colour mapper: hero glyph sprite, circular bullets and blue gradient background.
// Latency: fixed 2 cycles from DrawX/DrawY/pix_valid to Red/Green/Blue/rgb_valid.
// Backpressure: none; one pixel per cycle, never stalls.
// Ports: Clk, Reset_n (async, active-low); frame_start loads sprite shadows;
//   pix_valid/DrawX/DrawY pixel in; HeroX/HeroY/glyph_code/transparent hero state;
//   BulletX/BulletY (packed per channel)/bullet_en bullet state; Red/Green/Blue/rgb_valid out.
// COORD_W must be at least 10 (the gradient uses DrawX[9:3]).
module sprite_color_mapper_pipe
  import sprite_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int BULLET_R    = 4,
  parameter int COORD_W     = 10
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [COORD_W-1:0]             HeroX,
  input  logic [COORD_W-1:0]             HeroY,
  input  logic [6:0]                     glyph_code,
  input  logic                           transparent,
  input  logic [NUM_BULLETS*COORD_W-1:0] BulletX,
  input  logic [NUM_BULLETS*COORD_W-1:0] BulletY,
  input  logic [NUM_BULLETS-1:0]         bullet_en,
  output logic [7:0]                     Red,
  output logic [7:0]                     Green,
  output logic [7:0]                     Blue,
  output logic                           rgb_valid
);

  localparam int SW = COORD_W + 1;   // signed difference width
  localparam int PW = 2 * SW;        // squared-distance width
  localparam logic signed [PW-1:0] R_SQ = PW'(BULLET_R * BULLET_R);

  // ---------------------------------------------------------------- shadows
  logic [COORD_W-1:0]             hero_x_q, hero_y_q;
  logic [6:0]                     glyph_q;
  logic                           transp_q;
  logic [NUM_BULLETS*COORD_W-1:0] bul_x_q, bul_y_q;
  logic [NUM_BULLETS-1:0]         bul_en_q;
  // Shadows come out of reset at zero, which would place a hero cell at the
  // origin; armed_q keeps the hero dark until the first frame_start.
  logic                           armed_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hero_x_q <= '0;
      hero_y_q <= '0;
      glyph_q  <= '0;
      transp_q <= 1'b0;
      bul_x_q  <= '0;
      bul_y_q  <= '0;
      bul_en_q <= '0;
      armed_q  <= 1'b0;
    end else if (frame_start) begin
      hero_x_q <= HeroX;
      hero_y_q <= HeroY;
      glyph_q  <= glyph_code;
      transp_q <= transparent;
      bul_x_q  <= BulletX;
      bul_y_q  <= BulletY;
      bul_en_q <= bullet_en;
      armed_q  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- stage 0
  logic signed [SW-1:0] dx, dy;
  logic                 hero_on;
  logic [10:0]          rom_addr;
  logic [NUM_BULLETS-1:0] hit;

  // Zero-extend before subtracting so positions near 0 / max give a true
  // negative difference instead of wrapping into range.
  assign dx = $signed({1'b0, DrawX}) - $signed({1'b0, hero_x_q});
  assign dy = $signed({1'b0, DrawY}) - $signed({1'b0, hero_y_q});

  // 0 <= dx <= 7 and 0 <= dy <= 15, expressed as sign bit clear and upper bits zero.
  assign hero_on = armed_q
                 & ~dx[SW-1] & (dx[SW-2:3] == '0)
                 & ~dy[SW-1] & (dy[SW-2:4] == '0);

  assign rom_addr = {glyph_q, dy[3:0]};

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_bullet
    logic signed [SW-1:0] bx, by;
    logic signed [PW-1:0] bx_w, by_w, dist_sq;

    assign bx      = $signed({1'b0, DrawX}) - $signed({1'b0, bul_x_q[i*COORD_W +: COORD_W]});
    assign by      = $signed({1'b0, DrawY}) - $signed({1'b0, bul_y_q[i*COORD_W +: COORD_W]});
    assign bx_w    = {{(PW-SW){bx[SW-1]}}, bx};
    assign by_w    = {{(PW-SW){by[SW-1]}}, by};
    assign dist_sq = bx_w * bx_w + by_w * by_w;
    assign hit[i]  = bul_en_q[i] && (dist_sq <= R_SQ);
  end

  logic [7:0] rom_data;

  font_rom_sync u_font_rom (
    .clk   (Clk),
    .rst_n (Reset_n),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  // ---------------------------------------------------------------- stage 1
  logic                   s1_hero_on;
  logic [2:0]             s1_dx;
  logic [NUM_BULLETS-1:0] s1_hit;
  logic [6:0]             s1_col;
  logic                   s1_vld;
  // Transparency travels with the pixel so a shadow reload while a pixel is
  // in flight cannot change how that pixel is drawn.
  logic                   s1_transp;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_hero_on <= 1'b0;
      s1_dx      <= '0;
      s1_hit     <= '0;
      s1_col     <= '0;
      s1_vld     <= 1'b0;
      s1_transp  <= 1'b0;
    end else begin
      s1_hero_on <= hero_on;
      s1_dx      <= dx[2:0];
      s1_hit     <= hit;
      s1_col     <= DrawX[9:3];
      s1_vld     <= pix_valid;
      s1_transp  <= transp_q;
    end
  end

  // Lowest-index hit wins when bullets overlap.
  logic [2:0] hit_idx;
  always_comb begin
    hit_idx = 3'd0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (s1_hit[i]) hit_idx = 3'(i);
    end
  end

  // MSB is the leftmost pixel, so the bit index is 7-dx, i.e. ~dx on 3 bits.
  logic glyph_bit;
  assign glyph_bit = rom_data[~s1_dx];

  rgb_t color_d;
  always_comb begin
    color_d = '0;
    if (!s1_vld)                                  color_d = '0;
    else if (s1_hero_on && glyph_bit)             color_d = HERO_FG;
    else if (s1_hero_on && !s1_transp)            color_d = HERO_BG;
    else if (|s1_hit)                             color_d = BULLET_RGB[hit_idx];
    else                                          color_d = background_rgb(s1_col);
  end

  // ---------------------------------------------------------------- stage 2
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red       <= 8'h00;
      Green     <= 8'h00;
      Blue      <= 8'h00;
      rgb_valid <= 1'b0;
    end else begin
      Red       <= color_d.r;
      Green     <= color_d.g;
      Blue      <= color_d.b;
      rgb_valid <= s1_vld;
    end
  end

endmodule

// File: tb/tb_sprite_color_mapper_pipe.sv
// Self-checking bench for sprite_color_mapper_pipe against a coordinate-level reference model.
// Latency: the model expects each pixel's colour exactly two clocks after it is driven.
// Backpressure: none exercised; the DUT accepts a pixel every cycle.
module tb_sprite_color_mapper_pipe;

  localparam int NB = 4;
  localparam int BR = 4;
  localparam int CW = 10;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [CW-1:0] DrawX = '0, DrawY = '0, HeroX = '0, HeroY = '0;
  logic [6:0]    glyph_code = '0;
  logic          transparent = 1'b0;
  logic [NB*CW-1:0] BulletX = '0, BulletY = '0;
  logic [NB-1:0] bullet_en = '0;
  logic [7:0]    Red, Green, Blue;
  logic          rgb_valid;

  int n_checks = 0;
  int n_errors = 0;

  sprite_color_mapper_pipe #(
    .NUM_BULLETS (NB),
    .BULLET_R    (BR),
    .COORD_W     (CW)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .HeroX       (HeroX),
    .HeroY       (HeroY),
    .glyph_code  (glyph_code),
    .transparent (transparent),
    .BulletX     (BulletX),
    .BulletY     (BulletY),
    .bullet_en   (bullet_en),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue),
    .rgb_valid   (rgb_valid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  // ------------------------------------------------------------ reference model
  localparam logic [23:0] C_FG = 24'hFF5500;
  localparam logic [23:0] C_BG = 24'h005500;
  localparam logic [23:0] C_BUL [8] = '{
    24'hFF5500, 24'h00FF00, 24'hFF00FF, 24'hFFFF00,
    24'h00FFFF, 24'hFFFFFF, 24'hFF0000, 24'h808080
  };
  localparam logic [7:0] FONT_A [16] = '{
    8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
    8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00
  };

  int         m_hx, m_hy;
  int         m_bx [NB];
  int         m_by [NB];
  logic [6:0] m_glyph;
  bit         m_transp, m_armed;
  logic [NB-1:0] m_en;

  logic [24:0] e_d1, e_d2, exp_now, obs;

  function automatic logic [7:0] font_row(input logic [6:0] g, input int row);
    if (g == 7'h41) return FONT_A[row];
    if (g == 7'h7F) return 8'hFF;
    return 8'h00;
  endfunction

  // {valid, r, g, b} for pixel (x,y) under the currently loaded frame state.
  function automatic logic [24:0] model_pixel(input int x, input int y, input bit v);
    int dx, dy, bx, by;
    logic [7:0] row;
    if (!v) return 25'd0;
    dx = x - m_hx;
    dy = y - m_hy;
    if (m_armed && dx >= 0 && dx < 8 && dy >= 0 && dy < 16) begin
      row = font_row(m_glyph, dy);
      if (row[7 - dx]) return {1'b1, C_FG};
      if (!m_transp)   return {1'b1, C_BG};
    end
    for (int i = 0; i < NB; i++) begin
      bx = x - m_bx[i];
      by = y - m_by[i];
      if (m_en[i] && (bx * bx + by * by <= BR * BR)) return {1'b1, C_BUL[i]};
    end
    return {1'b1, 8'h00, 8'h00, 8'(127 - x / 8)};
  endfunction

  task automatic load_model();
    m_hx = int'(HeroX);
    m_hy = int'(HeroY);
    m_glyph = glyph_code;
    m_transp = transparent;
    m_en = bullet_en;
    for (int i = 0; i < NB; i++) begin
      m_bx[i] = int'(BulletX[i*CW +: CW]);
      m_by[i] = int'(BulletY[i*CW +: CW]);
    end
    m_armed = 1'b1;
  endtask

  task automatic reset_model();
    m_hx = 0; m_hy = 0; m_glyph = '0; m_transp = 1'b0; m_en = '0; m_armed = 1'b0;
    for (int i = 0; i < NB; i++) begin m_bx[i] = 0; m_by[i] = 0; end
    e_d1 = 25'd0;
    e_d2 = 25'd0;
  endtask

  // One pixel slot: sample the output due now, then drive the next pixel.
  // Returns just after the capturing posedge so callers may change sprite inputs safely.
  task automatic tick_pixel(input int x, input int y, input bit v, input bit fs);
    @(negedge Clk);
    obs = {rgb_valid, Red, Green, Blue};
    exp_now = e_d2;
    e_d2 = e_d1;
    e_d1 = model_pixel(x, y, v);
    DrawX = CW'(x);
    DrawY = CW'(y);
    pix_valid = v;
    frame_start = fs;
    if (fs) load_model();
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic set_bullet(input int i, input int x, input int y);
    BulletX[i*CW +: CW] = CW'(x);
    BulletY[i*CW +: CW] = CW'(y);
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset();
    #1;
    Reset_n = 1'b0;
    reset_model();
    #2;
    n_checks++;
    if ({rgb_valid, Red, Green, Blue} !== 25'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %07h want 0000000", {rgb_valid, Red, Green, Blue});
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    // Shadows hold the origin but no frame_start yet: only background may appear.
    for (int i = 0; i < 12; i++) begin
      tick_pixel(i % 10, i % 3, (i < 10), 1'b0);
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL reset_no_draw slot=%0d: got %07h want %07h", i, obs, exp_now);
      end
    end
  endtask

  task automatic test_hero_row();
    HeroX = 10'd100; HeroY = 10'd50; glyph_code = 7'h41; transparent = 1'b0;
    tick_pixel(0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 28; k++) begin
      if (k < 26) tick_pixel(98 + (k % 13), (k < 13) ? 50 : 55, 1'b1, 1'b0);
      else        tick_pixel(0, 0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL hero_row slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
  endtask

  task automatic test_bullet_radius();
    int px [6] = '{204, 203, 204, 205, 196, 200};
    int py [6] = '{200, 202, 201, 200, 200, 205};
    set_bullet(0, 200, 200);
    bullet_en = 4'b0001;
    tick_pixel(0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k < 6) tick_pixel(px[k], py[k], 1'b1, 1'b0);
      else       tick_pixel(0, 0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL bullet_radius slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
  endtask

  task automatic test_bullet_overlap();
    int px [4] = '{300, 302, 296, 301};
    int py [4] = '{300, 301, 300, 303};
    set_bullet(1, 300, 300);
    set_bullet(2, 300, 300);
    for (int pass = 0; pass < 2; pass++) begin
      bullet_en = (pass == 0) ? 4'b0111 : 4'b0101;
      tick_pixel(0, 0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
        if (k < 4) tick_pixel(px[k], py[k], 1'b1, 1'b0);
        else       tick_pixel(0, 0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== exp_now) begin
          n_errors++;
          $display("FAIL bullet_overlap pass=%0d slot=%0d: got %07h want %07h", pass, k, obs, exp_now);
        end
      end
    end
  endtask

  task automatic test_transparent();
    HeroX = 10'd196; HeroY = 10'd192; glyph_code = 7'h41; transparent = 1'b1;
    bullet_en = 4'b0001;
    tick_pixel(0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 28; k++) begin
      if (k < 26) tick_pixel(194 + (k % 13), (k < 13) ? 200 : 197, 1'b1, 1'b0);
      else        tick_pixel(0, 0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL transparent slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
  endtask

  task automatic test_shadow_timing();
    HeroX = 10'd400; HeroY = 10'd100; glyph_code = 7'h7F; transparent = 1'b0;
    tick_pixel(0, 0, 1'b0, 1'b1);
    HeroX = 10'd500;   // no frame_start: must not take effect
    for (int k = 0; k < 13; k++) begin
      tick_pixel(398 + k, 100, 1'b1, 1'b0);
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL midframe_hold slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
    // Pixel sharing the frame_start cycle still sees x=400; the next ones see x=500.
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       tick_pixel(403, 100, 1'b1, 1'b1);
        1:       tick_pixel(403, 100, 1'b1, 1'b0);
        2:       tick_pixel(503, 100, 1'b1, 1'b0);
        3:       tick_pixel(499, 100, 1'b1, 1'b0);
        default: tick_pixel(0, 0, 1'b0, 1'b0);
      endcase
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL frame_start_edge slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
  endtask

  task automatic test_blanking_and_reset();
    for (int k = 0; k < 16; k++) begin
      tick_pixel(500 + (k % 8), 100, (k >= 8), 1'b0);
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL blanking slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rgb_valid, Red, Green, Blue} !== 25'd0) begin
      n_errors++;
      $display("FAIL midline_reset: got %07h want 0000000", {rgb_valid, Red, Green, Blue});
    end
    reset_model();
    pix_valid = 1'b0;
    frame_start = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      case (k)
        0, 1, 2: tick_pixel(501 + k, 100, 1'b1, 1'b0);
        3:       tick_pixel(200, 200, 1'b1, 1'b0);
        4:       tick_pixel(0, 0, 1'b0, 1'b1);
        5:       tick_pixel(503, 100, 1'b1, 1'b0);
        6:       tick_pixel(200, 200, 1'b1, 1'b0);
        default: tick_pixel(0, 0, 1'b0, 1'b0);
      endcase
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL post_reset slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
  endtask

  function automatic int pick_coord();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return $urandom_range(0, 6);
    if (r == 1) return $urandom_range(1017, 1023);
    return $urandom_range(0, 1023);
  endfunction

  task automatic test_random();
    logic [6:0] glyphs [3] = '{7'h41, 7'h7F, 7'h20};
    int t, x, y;
    for (int f = 0; f < 16; f++) begin
      HeroX = CW'(pick_coord());
      HeroY = CW'(pick_coord());
      glyph_code = glyphs[$urandom_range(0, 2)];
      transparent = 1'($urandom_range(0, 1));
      for (int i = 0; i < NB; i++) set_bullet(i, pick_coord(), pick_coord());
      bullet_en = NB'($urandom);
      for (int p = 0; p < 82; p++) begin
        t = $urandom_range(0, NB);
        if (t == NB) begin
          x = (m_hx + $urandom_range(0, 16) - 4 + 1024) % 1024;
          y = (m_hy + $urandom_range(0, 24) - 4 + 1024) % 1024;
        end else begin
          x = (m_bx[t] + $urandom_range(0, 12) - 6 + 1024) % 1024;
          y = (m_by[t] + $urandom_range(0, 12) - 6 + 1024) % 1024;
        end
        if (p == 0) tick_pixel(x, y, 1'($urandom_range(0, 1)), 1'b1);
        else        tick_pixel(x, y, ($urandom_range(0, 3) != 0), 1'b0);
        n_checks++;
        if (obs !== exp_now) begin
          n_errors++;
          $display("FAIL random frame=%0d slot=%0d: got %07h want %07h", f, p, obs, exp_now);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick_pixel(0, 0, 1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_now) begin
        n_errors++;
        $display("FAIL random_flush slot=%0d: got %07h want %07h", k, obs, exp_now);
      end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_hero_row();
    test_bullet_radius();
    test_bullet_overlap();
    test_transparent();
    test_shadow_timing();
    test_blanking_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
